// File: rtl/z80_bus_responder.sv
// z80_bus_responder: Z80 bus target serving on-chip RAM, an 8-port I/O bank, wait states and IM2 interrupts.
module z80_bus_responder #(
  parameter int          MEM_AW     = 12,
  parameter logic [15:0] WP_TOP     = 16'h0100,
  parameter int          MEM_WAIT   = 1,
  parameter int          FETCH_WAIT = 0,
  parameter logic [7:0]  IO_BASE    = 8'h00,
  parameter logic [7:0]  IM2_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_from_cpu,
  output logic [7:0]  data_to_cpu,
  output logic        data_valid,
  input  logic        MREQ_L,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic        M1_L,
  output logic        WAIT_L,
  output logic        INT_L,
  input  logic        int_req,
  output logic [63:0] io_ports,
  output logic        wp_violation,
  output logic        bus_err
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACC = 2'd2, S_HOLD = 2'd3;
  localparam logic [2:0] C_MRD = 3'd0, C_MWR = 3'd1, C_IRD = 3'd2, C_IWR = 3'd3, C_INTA = 3'd4, C_ERR = 3'd5;

  logic [7:0]  mem [0:(1<<MEM_AW)-1];
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, nwait;
  logic [15:0] addr_q;
  logic [2:0]  cls_q, cls;
  logic [7:0]  wdat_q, dout_q, ioff;
  logic [63:0] io_q;
  logic        dv_q, dv_d, wait_l_q, pend_q, wp_q, err_q;
  logic        illegal, inta, req, all_high, acc, io_hit;

  always_comb begin
    illegal  = (!RD_L && !WR_L) || (!MREQ_L && !IORQ_L);
    inta     = !M1_L && !IORQ_L;
    req      = illegal || inta || ((!MREQ_L || !IORQ_L) && (!RD_L || !WR_L));
    cls      = illegal ? C_ERR : inta ? C_INTA : !MREQ_L ? (!RD_L ? C_MRD : C_MWR) : (!RD_L ? C_IRD : C_IWR);
    nwait    = (illegal || inta) ? 4'd0 : (!MREQ_L && !RD_L && !M1_L) ? 4'(FETCH_WAIT) : 4'(MEM_WAIT);
    all_high = MREQ_L && IORQ_L && RD_L && WR_L;
    acc      = state_q == S_ACC;
    ioff     = addr_q[7:0] - IO_BASE;
    io_hit   = ioff[7:3] == 5'd0;
    state_d  = state_q == S_IDLE ? (!req ? S_IDLE : illegal ? S_HOLD : nwait != 4'd0 ? S_WAIT : S_ACC)
             : state_q == S_WAIT ? (cnt_q <= 4'd1 ? S_ACC : S_WAIT)
             : state_q == S_ACC  ? S_HOLD
             : (all_high ? S_IDLE : S_HOLD);
    cnt_d    = state_q == S_IDLE ? nwait : state_q == S_WAIT ? cnt_q - 4'd1 : cnt_q;
    dv_d     = acc ? (cls_q == C_MRD || cls_q == C_IRD || cls_q == C_INTA) : (state_q == S_HOLD && dv_q && !all_high);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wait_l_q <= 1'b1;
      dv_q     <= 1'b0;
      dout_q   <= 8'd0;
      pend_q   <= 1'b0;
      wp_q     <= 1'b0;
      err_q    <= 1'b0;
      io_q     <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_l_q <= state_d != S_WAIT;
      dv_q     <= dv_d;
      // a request arriving in the acknowledge cycle wins over the clear
      pend_q   <= int_req || (pend_q && !(acc && cls_q == C_INTA));
      if (state_q == S_IDLE && req && illegal) err_q <= 1'b1;
      if (acc && cls_q == C_MWR && addr_q < WP_TOP) wp_q <= 1'b1;
      if (acc && cls_q == C_IWR && io_hit) io_q[{ioff[2:0], 3'b000} +: 8] <= wdat_q;
      if (acc) dout_q <= cls_q == C_MRD ? mem[addr_q[MEM_AW-1:0]]
                       : cls_q == C_IRD ? (io_hit ? io_q[{ioff[2:0], 3'b000} +: 8] : 8'hFF)
                       : cls_q == C_INTA ? IM2_VECTOR : dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      addr_q <= addr_bus;
      cls_q  <= cls;
      wdat_q <= data_from_cpu;
    end
    if (!rst && acc && cls_q == C_MWR && addr_q >= WP_TOP) mem[addr_q[MEM_AW-1:0]] <= wdat_q;
  end

  assign data_to_cpu  = dout_q;
  assign data_valid   = dv_q;
  assign WAIT_L       = wait_l_q;
  assign INT_L        = !pend_q;
  assign io_ports     = io_q;
  assign wp_violation = wp_q;
  assign bus_err      = err_q;
endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder: directed bus cycles; read data checked by a queue-based monitor.
module tb_z80_bus_responder;
  localparam logic [4:0] B_IDLE = 5'b11111, B_MRD = 5'b01011, B_MWR = 5'b01101, B_FETCH = 5'b01010,
                         B_IRD = 5'b10011, B_IWR = 5'b10101, B_INTA = 5'b10110, B_ERR = 5'b01001;

  logic        clk = 0, rst = 1, int_req = 0;
  logic [15:0] addr = 0;
  logic [7:0]  wdat = 0;
  logic        mreq = 1, iorq = 1, rd = 1, wr = 1, m1 = 1;
  logic        mreq2 = 1, iorq2 = 1, rd2 = 1, wr2 = 1, m12 = 1;
  logic [7:0]  d1, d2;
  logic        dv1, dv2, wl1, wl2, il1, il2, wp1, wp2, be1, be2;
  logic [63:0] io1, io2;
  logic [7:0]  q1[$], q2[$];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  z80_bus_responder u_dut (
    .clk(clk), .rst(rst), .addr_bus(addr), .data_from_cpu(wdat), .data_to_cpu(d1), .data_valid(dv1),
    .MREQ_L(mreq), .IORQ_L(iorq), .RD_L(rd), .WR_L(wr), .M1_L(m1), .WAIT_L(wl1), .INT_L(il1),
    .int_req(int_req), .io_ports(io1), .wp_violation(wp1), .bus_err(be1));

  z80_bus_responder #(.MEM_WAIT(3), .FETCH_WAIT(2)) u_w3 (
    .clk(clk), .rst(rst), .addr_bus(addr), .data_from_cpu(wdat), .data_to_cpu(d2), .data_valid(dv2),
    .MREQ_L(mreq2), .IORQ_L(iorq2), .RD_L(rd2), .WR_L(wr2), .M1_L(m12), .WAIT_L(wl2), .INT_L(il2),
    .int_req(1'b0), .io_ports(io2), .wp_violation(wp2), .bus_err(be2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic p1 = 0, p2 = 0;
    forever begin
      @(negedge clk);
      if (dv1 && !p1) begin
        if (q1.size() == 0) chk("unexpected_dv1", {56'd0, d1}, 64'hDEAD);
        else chk("rd_data1", {56'd0, d1}, {56'd0, q1.pop_front()});
      end
      if (dv2 && !p2) begin
        if (q2.size() == 0) chk("unexpected_dv2", {56'd0, d2}, 64'hDEAD);
        else chk("rd_data2", {56'd0, d2}, {56'd0, q2.pop_front()});
      end
      p1 = dv1;
      p2 = dv2;
    end
  end

  task automatic drive(input bit sel, input logic [4:0] s);
    if (sel) {mreq2, iorq2, rd2, wr2, m12} = s;
    else {mreq, iorq, rd, wr, m1} = s;
  endtask

  task automatic bus_cycle(input bit sel, input logic [4:0] s, input logic [15:0] a, input logic [7:0] d,
                           input bit rdx, input logic [7:0] e, input int lat, input int wt, input int irq_k,
                           input string nm);
    int fl = -1, wc = 0;
    @(posedge clk); #1;
    drive(sel, s);
    addr = a;
    wdat = d;
    if (rdx) begin
      if (sel) q2.push_back(e);
      else q1.push_back(e);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      int_req = (k == irq_k);
      if (!(sel ? wl2 : wl1)) wc++;
      if ((sel ? dv2 : dv1) && fl < 0) fl = k;
    end
    int_req = 0;
    if (rdx) chk({nm, "_lat"}, 64'(fl), 64'(lat));
    chk({nm, "_wait"}, 64'(wc), 64'(wt));
    @(posedge clk); #1;
    drive(sel, B_IDLE);
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_dv_drop"}, {63'd0, sel ? dv2 : dv1}, 64'd0);
  endtask

  task automatic pulse_irq;
    @(posedge clk); #1;
    int_req = 1;
    @(negedge clk);
    chk("int_same_cycle", {63'd0, il1}, 64'd1);
    @(posedge clk); #1;
    int_req = 0;
    @(negedge clk);
    chk("int_next_cycle", {63'd0, il1}, 64'd0);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_dout"}, {56'd0, d1}, 64'd0);
    chk({nm, "_dv"}, {63'd0, dv1}, 64'd0);
    chk({nm, "_wait_l"}, {63'd0, wl1}, 64'd1);
    chk({nm, "_int_l"}, {63'd0, il1}, 64'd1);
    chk({nm, "_io"}, io1, 64'd0);
    chk({nm, "_wp"}, {63'd0, wp1}, 64'd0);
    chk({nm, "_err"}, {63'd0, be1}, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    reset_vals("reset");
    bus_cycle(0, B_MWR, 16'h0200, 8'hA5, 0, 8'h00, 0, 1, -1, "mwr_0200");
    bus_cycle(0, B_MRD, 16'h0200, 8'h00, 1, 8'hA5, 3, 1, -1, "mrd_0200");
    bus_cycle(0, B_MWR, 16'h1010, 8'h66, 0, 8'h00, 0, 1, -1, "mwr_1010");
    chk("wp_clear", {63'd0, wp1}, 64'd0);
    bus_cycle(0, B_MWR, 16'h0010, 8'h3C, 0, 8'h00, 0, 1, -1, "mwr_prot");
    chk("wp_set", {63'd0, wp1}, 64'd1);
    bus_cycle(0, B_MRD, 16'h0010, 8'h00, 1, 8'h66, 3, 1, -1, "mrd_prot");
    bus_cycle(0, B_MWR, 16'h0300, 8'h9E, 0, 8'h00, 0, 1, -1, "mwr_0300");
    bus_cycle(0, B_FETCH, 16'h0300, 8'h00, 1, 8'h9E, 2, 0, -1, "fetch_0300");
    bus_cycle(0, B_MWR, 16'h1005, 8'h42, 0, 8'h00, 0, 1, -1, "mwr_1005");
    bus_cycle(0, B_MRD, 16'h0005, 8'h00, 1, 8'h42, 3, 1, -1, "mrd_wrap");
    bus_cycle(0, B_IWR, 16'hAB03, 8'h5A, 0, 8'h00, 0, 1, -1, "iowr_03");
    chk("io_port3", io1, 64'h00000000_5A000000);
    bus_cycle(0, B_IRD, 16'h1203, 8'h00, 1, 8'h5A, 3, 1, -1, "iord_03");
    bus_cycle(0, B_IRD, 16'h0040, 8'h00, 1, 8'hFF, 3, 1, -1, "iord_40");
    bus_cycle(0, B_IWR, 16'h0040, 8'h77, 0, 8'h00, 0, 1, -1, "iowr_40");
    chk("io_unmapped", io1, 64'h00000000_5A000000);
    chk("int_idle", {63'd0, il1}, 64'd1);
    pulse_irq();
    @(posedge clk); #1 int_req = 1;
    @(posedge clk); #1 int_req = 0;
    @(negedge clk);
    chk("int_absorbed", {63'd0, il1}, 64'd0);
    bus_cycle(0, B_INTA, 16'h0000, 8'h00, 1, 8'hFF, 2, 0, -1, "inta");
    chk("int_cleared", {63'd0, il1}, 64'd1);
    pulse_irq();
    bus_cycle(0, B_INTA, 16'h0000, 8'h00, 1, 8'hFF, 2, 0, 1, "inta_coinc");
    chk("int_kept", {63'd0, il1}, 64'd0);
    chk("err_clear", {63'd0, be1}, 64'd0);
    bus_cycle(0, B_ERR, 16'h0200, 8'h00, 0, 8'h00, 0, 0, -1, "illegal");
    chk("err_set", {63'd0, be1}, 64'd1);
    bus_cycle(0, B_MRD, 16'h0200, 8'h00, 1, 8'hA5, 3, 1, -1, "mrd_after_err");
    chk("wp_sticky", {63'd0, wp1}, 64'd1);
    chk("err_sticky", {63'd0, be1}, 64'd1);
    bus_cycle(1, B_MWR, 16'h0500, 8'hC3, 0, 8'h00, 0, 3, -1, "w3_mwr");
    bus_cycle(1, B_MRD, 16'h0500, 8'h00, 1, 8'hC3, 5, 3, -1, "w3_mrd");
    bus_cycle(1, B_FETCH, 16'h0500, 8'h00, 1, 8'hC3, 4, 2, -1, "w3_fetch");
    bus_cycle(0, B_MWR, 16'h0400, 8'h11, 0, 8'h00, 0, 1, -1, "mwr_0400");
    @(posedge clk); #1;
    drive(0, B_MWR);
    addr = 16'h0400;
    wdat = 8'h77;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("rst_in_wait", {63'd0, wl1}, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    drive(0, B_IDLE);
    @(negedge clk);
    reset_vals("midrst");
    bus_cycle(0, B_MRD, 16'h0400, 8'h00, 1, 8'h11, 3, 1, -1, "mrd_after_rst");
    repeat (3) @(negedge clk);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q2_empty", 64'(q2.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Slave/target end of the z80 CPU bus: decodes MREQ_L/IORQ_L/RD_L/WR_L/M1_L and serves memory reads/writes from an on-chip RAM array.
- Serves I/O reads/writes from an 8-register port bank; inserts programmable WAIT_L states.
- Raises INT_L and supplies an IM2 vector on the interrupt-acknowledge cycle.
- Sits between the z80 top and the board, in place of external RAM/peripherals.

Parameters:
- MEM_AW, 12, RAM address width; depth 2**MEM_AW bytes; CPU address upper bits ignored (mirror/wrap).
- WP_TOP, 16'h0100, addresses below this are write-protected (ROM image region).
- MEM_WAIT, 1, wait states for non-M1 memory and I/O accesses (0..15).
- FETCH_WAIT, 0, wait states for M1 opcode fetch (0..15).
- IO_BASE, 8'h00, first of 8 consecutive I/O ports (addr_bus[7:0]).
- IM2_VECTOR, 8'hFF, byte returned on interrupt acknowledge.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- addr_bus  in  16  CPU address
- data_from_cpu  in  8  CPU write data (CPU data_out)
- data_to_cpu  out  8  read data to CPU (CPU data_in)
- data_valid  out  1  data_to_cpu holds valid read/vector data
- MREQ_L, IORQ_L, RD_L, WR_L, M1_L  in  1 each  CPU strobes, active-low
- WAIT_L  out  1  wait request to CPU, active-low
- INT_L  out  1  maskable interrupt to CPU, active-low
- int_req  in  1  single-cycle interrupt request from peripherals
- io_ports  out  64  port bank contents, port k at bits [8k+7:8k]
- wp_violation  out  1  sticky: write into protected region attempted
- bus_err  out  1  sticky: illegal strobe combination seen

Behaviour:
- Reset values: data_to_cpu=0, data_valid=0, WAIT_L=1, INT_L=1, io_ports=0, wp_violation=0, bus_err=0, FSM=IDLE. RAM contents not cleared. Reset mid-access aborts immediately; a pending write not yet committed is dropped.
- Request classes, sampled in IDLE:
  - MEMRD = MREQ_L=0 & RD_L=0.
  - MEMWR = MREQ_L=0 & WR_L=0.
  - IORD / IOWR = IORQ_L=0 with RD_L / WR_L low.
  - INTA = M1_L=0 & IORQ_L=0.
  - FETCH = MEMRD with M1_L=0.
- Illegal combinations: RD_L&WR_L both low; MREQ_L&IORQ_L both low. These set bus_err, perform no access, and go to HOLD.
- FSM IDLE->WAIT->ACCESS->HOLD->IDLE:
  - IDLE, cycle T, request seen: latch addr, class, write data. Wait count N = FETCH_WAIT for FETCH, MEM_WAIT otherwise, 0 for INTA. Next state is WAIT if N>0, else ACCESS.
  - WAIT: WAIT_L=0 for exactly N cycles (T+1..T+N), registered; counter decrements.
  - ACCESS, one cycle:
    - Write commit: RAM[addr[MEM_AW-1:0]] unless addr<WP_TOP, in which case set wp_violation and drop the write. IOWR to port p in [IO_BASE, IO_BASE+7] updates io_ports; other ports are dropped.
    - Read: data_to_cpu loaded with the RAM byte, the port value, 8'hFF for an unmapped port, or IM2_VECTOR for INTA.
    - WAIT_L=1.
  - HOLD: data_valid=1 for reads/INTA, from cycle after ACCESS until all of MREQ_L, IORQ_L, RD_L, WR_L high, then IDLE. Exactly one access per strobe assertion; a strobe held low never re-triggers.
- Read latency: data_valid rises N+2 cycles after request detect.
- Interrupt:
  - int_req=1 sets pending; INT_L=0 the next cycle.
  - int_req while pending is absorbed (not counted).
  - INT_L returns high in the cycle after INTA ACCESS.
  - int_req coincident with INTA ACCESS leaves pending set, so INT_L stays low.
- Address wrap: addr 16'h1005 with MEM_AW=12 accesses RAM[12'h005]; the protect check uses the full 16-bit address.

Test Plan:
- MEMWR addr 16'h0200 data 8'hA5, MEM_WAIT=1 -> WAIT_L low 1 cycle. Then MEMRD 16'h0200 -> data_valid at T+3 with data_to_cpu=8'hA5; data_valid drops after RD_L/MREQ_L release.
- MEMWR 16'h0010 data 8'h3C (below WP_TOP) -> RAM unchanged (readback returns prior value), wp_violation=1 and stays set until rst.
- FETCH (M1_L=0) at 16'h0300, FETCH_WAIT=0 -> no WAIT_L pulse; data_valid at T+2. MEM_WAIT=3 non-M1 read -> WAIT_L low exactly 3 cycles.
- IOWR port 8'h03 data 8'h5A -> io_ports[31:24]=8'h5A. IORD port 8'h03 -> 8'h5A. IORD port 8'h40 -> 8'hFF. IOWR port 8'h40 -> io_ports unchanged.
- int_req pulse -> INT_L=0 next cycle. Second int_req -> no change. INTA -> data_to_cpu=8'hFF (IM2_VECTOR), INT_L=1 after ACCESS. Repeat with int_req coincident with ACCESS -> INT_L stays 0.
- RD_L and WR_L both low with MREQ_L=0 -> bus_err=1, no RAM change. Assert rst during WAIT state of a MEMWR -> WAIT_L=1 next cycle, write not committed, FSM idle, all outputs at reset values.
